// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared 7-segment display constants and decode helpers
package fnd_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] COM_DIG0 = 4'b1110;
    localparam logic [3:0] COM_DIG1 = 4'b1101;
    localparam logic [3:0] COM_DIG2 = 4'b1011;
    localparam logic [3:0] COM_DIG3 = 4'b0111;
    localparam logic [3:0] COM_OFF  = 4'b1111;

    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] com_select(input digit_idx_t idx);
        case (idx)
            2'd0:    return COM_DIG0;
            2'd1:    return COM_DIG1;
            2'd2:    return COM_DIG2;
            default: return COM_DIG3;
        endcase
    endfunction

    // Decimal digit idx (0 = ones) of a 0..9999 binary value.
    function automatic logic [3:0] bcd_digit(input logic [13:0] value, input digit_idx_t idx);
        logic [13:0] q;
        q = value;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < idx) q = q / 14'd10;
        end
        return 4'(q % 14'd10);
    endfunction

endpackage

// File: rtl/down_counter_if.sv
// rtl/down_counter_if.sv - control and display signal bundle for the countdown timer
interface down_counter_if;
    logic       run;
    logic       clear;
    logic       borrow;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    modport master (output run, clear, input borrow, fnd_com, fnd_data);
    modport slave  (input run, clear, output borrow, fnd_com, fnd_data);
endinterface

// File: rtl/fnd_controller.sv
// rtl/fnd_controller.sv - four-digit common-anode scan driver for a 0..9999 value
module fnd_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    digit_idx_t    digit_idx;
    logic [3:0]    digit;

    assign digit = bcd_digit(value, digit_idx);

    // Select and segments load on the same edge so a frame never mixes digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            fnd_com   <= COM_OFF;
            fnd_data  <= SEG_BLANK;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            fnd_com  <= com_select(digit_idx);
            fnd_data <= seg_decode(digit);
        end
    end

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - four-digit decimal countdown timer with wrap borrow and FND output
module down_counter #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int START_VAL = 9999
) (
    input  logic           clk,
    input  logic           reset,
    down_counter_if.slave  bus
);

    localparam int          TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [13:0] START = 14'(START_VAL);

    logic [TW-1:0] tick_cnt;
    logic [13:0]   count;
    logic          borrow_q;

    assign bus.borrow = borrow_q;

    // The divider only moves on run-cycles, so pausing keeps the partial period.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            count    <= START;
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= 1'b0;
            if (bus.clear) begin
                tick_cnt <= '0;
                count    <= START;
            end else if (bus.run) begin
                if (tick_cnt == TW'(TICK_DIV - 1)) begin
                    tick_cnt <= '0;
                    if (count == 14'd0) begin
                        count    <= START;
                        borrow_q <= 1'b1;
                    end else begin
                        count <= count - 14'd1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

    fnd_controller #(.SCAN_DIV(SCAN_DIV)) u_fnd (
        .clk      (clk),
        .reset    (reset),
        .value    (count),
        .fnd_com  (bus.fnd_com),
        .fnd_data (bus.fnd_data)
    );

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - self-checking bench for down_counter
module tb_down_counter;

    localparam int TICK_DIV  = 4;
    localparam int SCAN_DIV  = 2;
    localparam int START_VAL = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    down_counter_if dif();

    down_counter #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .START_VAL(START_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    int checks = 0;
    int errors = 0;

    int         m_count;
    int         m_runs;
    int         m_cycles;
    logic [3:0] e_com;
    logic [7:0] e_data;
    logic       e_borrow;
    logic [7:0] seg_tab [10];

    typedef struct {
        logic       rst;
        logic       run;
        logic       clr;
        logic [3:0] com;
        logic [7:0] data;
        logic       brw;
    } vec_t;

    vec_t tab [11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: display shows the digit chosen by elapsed scan slots of the
    // pre-edge count; steps happen every TICK_DIV run-cycles.
    task automatic model_edge();
        int idx;
        int p;
        if (reset) begin
            m_count  = START_VAL;
            m_runs   = 0;
            m_cycles = 0;
            e_com    = 4'b1111;
            e_data   = 8'hFF;
            e_borrow = 1'b0;
        end else begin
            idx = (m_cycles / SCAN_DIV) % 4;
            m_cycles++;
            p = 1;
            for (int i = 0; i < idx; i++) p = p * 10;
            e_com      = 4'b1111;
            e_com[idx] = 1'b0;
            e_data     = seg_tab[(m_count / p) % 10];
            e_borrow   = 1'b0;
            if (dif.clear) begin
                m_count = START_VAL;
                m_runs  = 0;
            end else if (dif.run) begin
                m_runs++;
                if (m_runs == TICK_DIV) begin
                    m_runs = 0;
                    if (m_count == 0) begin
                        m_count  = START_VAL;
                        e_borrow = 1'b1;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("fnd_com", dif.fnd_com, e_com);
        check("fnd_data", dif.fnd_data, e_data);
        check("borrow", dif.borrow, e_borrow);
    endtask

    initial begin
        int n;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        dif.run   = 1'b0;
        dif.clear = 1'b0;
        reset     = 1'b1;

        // Reset, then the first count step and scan slots with run held high.
        tab[0]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 8'hFF, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 1'b0, 4'b1110, 8'hA4, 1'b0};
        tab[2]  = '{1'b0, 1'b1, 1'b0, 4'b1110, 8'hA4, 1'b0};
        tab[3]  = '{1'b0, 1'b1, 1'b0, 4'b1101, 8'hF9, 1'b0};
        tab[4]  = '{1'b0, 1'b1, 1'b0, 4'b1101, 8'hF9, 1'b0};
        tab[5]  = '{1'b0, 1'b1, 1'b0, 4'b1011, 8'hC0, 1'b0};
        tab[6]  = '{1'b0, 1'b1, 1'b0, 4'b1011, 8'hC0, 1'b0};
        tab[7]  = '{1'b0, 1'b1, 1'b0, 4'b0111, 8'hC0, 1'b0};
        tab[8]  = '{1'b0, 1'b1, 1'b0, 4'b0111, 8'hC0, 1'b0};
        tab[9]  = '{1'b0, 1'b1, 1'b0, 4'b1110, 8'hC0, 1'b0};
        tab[10] = '{1'b0, 1'b1, 1'b0, 4'b1110, 8'hC0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            reset     = tab[i].rst;
            dif.run   = tab[i].run;
            dif.clear = tab[i].clr;
            cycle();
            check("tab_com", dif.fnd_com, tab[i].com);
            check("tab_data", dif.fnd_data, tab[i].data);
            check("tab_borrow", dif.borrow, tab[i].brw);
        end

        // Wrap: borrow must appear and last exactly one cycle.
        n = 0;
        while (dif.borrow !== 1'b1 && n < 200) begin
            cycle();
            n++;
        end
        check("wrap_borrow_seen", int'(dif.borrow === 1'b1), 1);
        cycle();
        check("wrap_borrow_single", dif.borrow, 0);

        // Hold two run-cycles into a period for ten cycles.
        n = 0;
        while (m_runs != 2 && n < 20) begin
            cycle();
            n++;
        end
        check("hold_phase_reached", int'(m_runs == 2), 1);
        dif.run = 1'b0;
        repeat (10) cycle();
        dif.run = 1'b1;
        repeat (12) cycle();

        // Clear landing on the step edge at count 5.
        n = 0;
        while (!(m_count == 5 && m_runs == TICK_DIV - 1) && n < 200) begin
            cycle();
            n++;
        end
        check("clear_point_reached", int'(m_count == 5 && m_runs == TICK_DIV - 1), 1);
        dif.clear = 1'b1;
        cycle();
        dif.clear = 1'b0;
        check("clear_no_borrow", dif.borrow, 0);
        repeat (10) cycle();

        // Reset mid-run at count 7.
        n = 0;
        while (m_count != 7 && n < 200) begin
            cycle();
            n++;
        end
        check("reset_point_reached", int'(m_count == 7), 1);
        reset = 1'b1;
        cycle();
        check("midreset_com", dif.fnd_com, 4'b1111);
        check("midreset_data", dif.fnd_data, 8'hFF);
        reset = 1'b0;
        cycle();
        check("restart_com", dif.fnd_com, 4'b1110);
        check("restart_data", dif.fnd_data, 8'hA4);

        // Random run/clear/reset traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            dif.run   = ($urandom_range(0, 3) != 0);
            dif.clear = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset     = 1'b0;
        dif.clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
